// File: rtl/xor_share_arbiter_if.sv
// Requester and datapath bundle of the shared XOR arbiter.
// The slave side is the arbiter; the master side is the requesters plus the external XOR bank.
interface xor_share_arbiter_if #(
    parameter int W    = 4,
    parameter int NREQ = 2
);
    logic [NREQ-1:0]   req_i;
    logic [NREQ*W-1:0] a_i;
    logic [NREQ*W-1:0] b_i;
    logic [NREQ-1:0]   gnt_o;
    logic [W-1:0]      xor_a_o;
    logic [W-1:0]      xor_b_o;
    logic [W-1:0]      xor_c_i;
    logic [W-1:0]      res_o;
    logic [1:0]        res_id_o;
    logic              res_valid_o;
    logic              res_unknown_o;
    logic              mismatch_o;
    logic [7:0]        mismatch_cnt_o;
    logic              busy_o;

    modport slave (
        input  req_i, a_i, b_i, xor_c_i,
        output gnt_o, xor_a_o, xor_b_o, res_o, res_id_o, res_valid_o,
               res_unknown_o, mismatch_o, mismatch_cnt_o, busy_o
    );

    modport master (
        output req_i, a_i, b_i, xor_c_i,
        input  gnt_o, xor_a_o, xor_b_o, res_o, res_id_o, res_valid_o,
               res_unknown_o, mismatch_o, mismatch_cnt_o, busy_o
    );
endinterface

// File: rtl/xor_share_arbiter.sv
// Round-robin share of one external W-bit XOR datapath with 4-state reference checking.
// Latency: grant 1 cycle after acceptance, result strobe LAT+2 cycles after; one job per LAT+3.
// Backpressure: requesters hold req until granted; no job is accepted until the current one retires.
module xor_share_arbiter #(
    parameter int W    = 4,
    parameter int NREQ = 2,
    parameter int LAT  = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    xor_share_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GRANT, WAIT, DONE} state_t;

    state_t          state_q, state_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [1:0]      id_q, id_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [W-1:0]    xa_q, xa_d;
    logic [W-1:0]    xb_q, xb_d;
    logic [W-1:0]    res_q, res_d;
    logic [1:0]      res_id_q, res_id_d;
    logic            vld_q, vld_d;
    logic            unk_q, unk_d;
    logic            mis_q, mis_d;
    logic            busy_q, busy_d;
    logic [7:0]      mcnt_q, mcnt_d;

    logic            found;
    logic            capture;
    logic [1:0]      win;
    logic [W-1:0]    ref_val;
    logic [W-1:0]    unk_bits;

    // Only a solid 1 counts as a request; search starts just after the last winner.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int off = 1; off <= NREQ; off++) begin
            if (!found && bus.req_i[(int'(ptr_q) + off) % NREQ] === 1'b1) begin
                found = 1'b1;
                win   = 2'((int'(ptr_q) + off) % NREQ);
            end
        end
    end

    always_comb begin
        unk_bits = '0;
        ref_val  = '0;
        for (int i = 0; i < W; i++) begin
            unk_bits[i] = !(xa_q[i] === 1'b0 || xa_q[i] === 1'b1) ||
                          !(xb_q[i] === 1'b0 || xb_q[i] === 1'b1);
            ref_val[i]  = unk_bits[i] ? 1'bx : (xa_q[i] ^ xb_q[i]);
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        cnt_d    = cnt_q;
        gnt_d    = '0;
        xa_d     = xa_q;
        xb_d     = xb_q;
        res_d    = res_q;
        res_id_d = res_id_q;
        vld_d    = 1'b0;
        unk_d    = unk_q;
        mis_d    = 1'b0;
        mcnt_d   = mcnt_q;
        capture  = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d    = GRANT;
                    ptr_d      = win;
                    id_d       = win;
                    gnt_d[win] = 1'b1;
                    xa_d       = bus.a_i[int'(win)*W +: W];
                    xb_d       = bus.b_i[int'(win)*W +: W];
                end
            end
            GRANT: begin
                cnt_d = 4'(LAT);
                if (LAT == 0) begin
                    state_d = DONE;
                    capture = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = DONE;
                    capture = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            res_d    = ref_val;
            res_id_d = id_q;
            vld_d    = 1'b1;
            unk_d    = |unk_bits;
            mis_d    = (bus.xor_c_i !== ref_val);
            xa_d     = '0;
            xb_d     = '0;
            if ((bus.xor_c_i !== ref_val) && mcnt_q != 8'hFF)
                mcnt_d = mcnt_q + 8'd1;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            ptr_q    <= 2'(NREQ - 1);
            id_q     <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            xa_q     <= '0;
            xb_q     <= '0;
            res_q    <= '0;
            res_id_q <= '0;
            vld_q    <= 1'b0;
            unk_q    <= 1'b0;
            mis_q    <= 1'b0;
            busy_q   <= 1'b0;
            mcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            xa_q     <= xa_d;
            xb_q     <= xb_d;
            res_q    <= res_d;
            res_id_q <= res_id_d;
            vld_q    <= vld_d;
            unk_q    <= unk_d;
            mis_q    <= mis_d;
            busy_q   <= busy_d;
            mcnt_q   <= mcnt_d;
        end
    end

    assign bus.gnt_o          = gnt_q;
    assign bus.xor_a_o        = xa_q;
    assign bus.xor_b_o        = xb_q;
    assign bus.res_o          = res_q;
    assign bus.res_id_o       = res_id_q;
    assign bus.res_valid_o    = vld_q;
    assign bus.res_unknown_o  = unk_q;
    assign bus.mismatch_o     = mis_q;
    assign bus.mismatch_cnt_o = mcnt_q;
    assign bus.busy_o         = busy_q;
endmodule

// File: tb/tb_xor_share_arbiter.sv
// Bench for xor_share_arbiter: randomized requesters against a job-level timing/result model.
// The model tracks accepted jobs by cycle number and derives every expected output from them.
module tb_xor_share_arbiter;
    localparam int W    = 4;
    localparam int NREQ = 2;
    localparam int LAT  = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    xor_share_arbiter_if #(.W(W), .NREQ(NREQ)) bus ();

    logic         fault;
    logic [W-1:0] fault_val;
    assign bus.xor_c_i = fault ? fault_val : (bus.xor_a_o ^ bus.xor_b_o);

    xor_share_arbiter #(.W(W), .NREQ(NREQ), .LAT(LAT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_tests, n_fail, cyc;

    // Job-level model state
    bit           job_act;
    int           acc, m_id, ptr, free_at, m_cnt, jobs_done;
    logic [W-1:0] m_a, m_b, hold_res;
    logic [1:0]   hold_id;
    logic         hold_unk;

    // Stimulus controls
    int              phase, raise_budget, raise_pct, op_mode;
    logic [NREQ-1:0] auto_mask, xreq_val;
    logic [W-1:0]    fix_a, fix_b;
    bit              rst_in_wait, post_rst, xreq_pending;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] xref(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++)
            r[i] = ($isunknown(a[i]) || $isunknown(b[i])) ? 1'bx : (a[i] ^ b[i]);
        return r;
    endfunction

    function automatic logic [W-1:0] rand_op(input int mode);
        logic [W-1:0] v;
        int s;
        v = W'($urandom);
        if (mode == 2) begin
            for (int i = 0; i < W; i++) begin
                s = $urandom_range(15);
                if (s == 0)      v[i] = 1'bx;
                else if (s == 1) v[i] = 1'bz;
            end
        end
        return v;
    endfunction

    task automatic model_reset();
        job_act  = 1'b0;
        ptr      = NREQ - 1;
        m_cnt    = 0;
        hold_res = '0;
        hold_id  = '0;
        hold_unk = 1'b0;
        free_at  = cyc + 1;
    endtask

    task automatic check_cycle();
        logic [NREQ-1:0] e_gnt;
        bit              e_vld, e_busy, e_mis;
        logic [W-1:0]    r, dp;
        e_gnt  = '0;
        e_vld  = 1'b0;
        e_busy = 1'b0;
        e_mis  = 1'b0;
        if (job_act) begin
            e_busy = (cyc >= acc + 1) && (cyc <= acc + LAT + 2);
            if (cyc == acc + 1) begin
                e_gnt[m_id] = 1'b1;
                chk("xor_a_grant", bus.xor_a_o, m_a);
                chk("xor_b_grant", bus.xor_b_o, m_b);
            end
            if (cyc == acc + LAT + 2) begin
                r        = xref(m_a, m_b);
                dp       = fault ? fault_val : (m_a ^ m_b);
                e_vld    = 1'b1;
                e_mis    = (dp !== r);
                hold_res = r;
                hold_id  = 2'(m_id);
                hold_unk = $isunknown({m_a, m_b});
                if (e_mis && m_cnt < 255) m_cnt++;
            end
        end else begin
            chk("xor_a_idle", bus.xor_a_o, '0);
            chk("xor_b_idle", bus.xor_b_o, '0);
        end
        if (post_rst && job_act && cyc == acc + 1) begin
            chk("post_rst_gnt", bus.gnt_o, 1);
            post_rst = 1'b0;
        end
        if (phase == 1 && e_vld) chk("single_res", bus.res_o, 4'b1100);
        chk("gnt",       bus.gnt_o,          e_gnt);
        chk("busy",      bus.busy_o,         e_busy);
        chk("res_valid", bus.res_valid_o,    e_vld);
        chk("mismatch",  bus.mismatch_o,     e_mis);
        chk("res",       bus.res_o,          hold_res);
        chk("res_id",    bus.res_id_o,       hold_id);
        chk("unknown",   bus.res_unknown_o,  hold_unk);
        chk("mcnt",      bus.mismatch_cnt_o, m_cnt);
        if (e_vld) begin
            job_act = 1'b0;
            free_at = acc + LAT + 3;
            jobs_done++;
        end
    endtask

    task automatic drive();
        if (xreq_pending) begin
            bus.req_i    = xreq_val;
            xreq_pending = 1'b0;
        end
        if (job_act && cyc == acc + 1) bus.req_i[m_id] = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (auto_mask[k] && raise_budget > 0 && bus.req_i[k] !== 1'b1 &&
                !(job_act && cyc == acc + 1 && k == m_id) &&
                $urandom_range(99) < raise_pct) begin
                bus.req_i[k]         = 1'b1;
                bus.a_i[k*W +: W]    = (op_mode == 1) ? fix_a : rand_op(op_mode);
                bus.b_i[k*W +: W]    = (op_mode == 1) ? fix_b : rand_op(op_mode);
                raise_budget--;
            end
        end
    endtask

    // Decide whether the edge ending the current cycle accepts a job.
    task automatic model_accept();
        int k;
        if (!job_act && cyc >= free_at) begin
            for (int off = 1; off <= NREQ; off++) begin
                k = (ptr + off) % NREQ;
                if (!job_act && bus.req_i[k] === 1'b1) begin
                    job_act = 1'b1;
                    acc     = cyc;
                    m_id    = k;
                    m_a     = bus.a_i[k*W +: W];
                    m_b     = bus.b_i[k*W +: W];
                    ptr     = k;
                end
            end
        end
    endtask

    task automatic handler();
        check_cycle();
        if (rst) begin
            rst = 1'b0;
        end else if (rst_in_wait && job_act && cyc == acc + 2) begin
            rst          = 1'b1;
            rst_in_wait  = 1'b0;
            model_reset();
            post_rst     = 1'b1;
            auto_mask    = '1;
            raise_budget = 2;
            raise_pct    = 100;
        end
        drive();
        if (!rst) model_accept();
    endtask

    task automatic next_cycle();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        handler();
    endtask

    task automatic run_phase(input int p, input int jobs, input int budget);
        int start, n;
        start = jobs_done;
        n     = 0;
        phase = p;
        while (jobs_done - start < jobs && n < budget) begin
            next_cycle();
            n++;
        end
        if (jobs_done - start < jobs) chk("job_budget", jobs_done - start, jobs);
        raise_budget = 0;
        n = 0;
        while ((job_act || bus.req_i !== '0) && n < 60) begin
            next_cycle();
            n++;
        end
        if (job_act || bus.req_i !== '0) chk("drain", {job_act, bus.req_i}, '0);
    endtask

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0; jobs_done = 0;
        post_rst = 1'b0; rst_in_wait = 1'b0; xreq_pending = 1'b0; xreq_val = '0;
        rst = 1'b1; fault = 1'b0; fault_val = '0;
        bus.req_i = '0; bus.a_i = '0; bus.b_i = '0;
        auto_mask = '0; raise_budget = 0; raise_pct = 0; op_mode = 0;
        fix_a = '0; fix_b = '0; phase = 0;
        model_reset();
        next_cycle();

        // single request on requester 0
        auto_mask = 2'b01; op_mode = 1; fix_a = 4'b1010; fix_b = 4'b0110;
        raise_pct = 100; raise_budget = 1;
        run_phase(1, 1, 20);

        // continuous contention
        auto_mask = 2'b11; op_mode = 0; raise_pct = 100; raise_budget = 8;
        run_phase(2, 8, 100);

        // 4-state operands on requester 1
        auto_mask = 2'b10; op_mode = 1; fix_a = 4'b1x0z; fix_b = 4'b11z0;
        raise_pct = 100; raise_budget = 1;
        run_phase(3, 1, 20);

        // stuck-at-zero datapath, saturating counter
        fault = 1'b1; fault_val = 4'b0000;
        auto_mask = 2'b01; op_mode = 1; fix_a = 4'b0001; fix_b = 4'b0000;
        raise_pct = 100; raise_budget = 300;
        run_phase(4, 300, 1300);
        chk("mcnt_saturated", bus.mismatch_cnt_o, 255);
        fault = 1'b0;

        // reset during WAIT
        auto_mask = 2'b10; op_mode = 0; raise_pct = 100; raise_budget = 1;
        rst_in_wait = 1'b1;
        run_phase(5, 2, 40);

        // x on a request line is not a request
        auto_mask = '0;
        xreq_val = {1'bx, 1'b0}; xreq_pending = 1'b1;
        phase = 6;
        repeat (10) next_cycle();
        xreq_val = '0; xreq_pending = 1'b1;
        run_phase(6, 0, 1);

        // randomized traffic, clean then faulty datapath
        auto_mask = 2'b11; op_mode = 2; raise_pct = 40; raise_budget = 60;
        run_phase(7, 60, 2000);
        fault = 1'b1; fault_val = rand_op(0);
        auto_mask = 2'b11; op_mode = 2; raise_pct = 40; raise_budget = 60;
        run_phase(8, 60, 2000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
